// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA timing lock and pixel recovery; INPUT_SYNC_EN adds 2-flop input synchronizers
module vga_rx_monitor #(
   parameter int CLKS_PER_PIX = 4,
   parameter int H_VISIBLE    = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_VISIBLE    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        HS,
   input  logic        VS,
   input  logic [11:0] COLOUR_IN,
   output logic        PIX_VALID,
   output logic [9:0]  X,
   output logic [8:0]  Y,
   output logic [11:0] COLOUR_OUT,
   output logic        LOCKED,
   output logic        FRAME_START,
   output logic        TIMING_ERR
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int PW      = $clog2(CLKS_PER_PIX);

   localparam logic [PW-1:0] PH_LAST    = PW'(CLKS_PER_PIX - 1);
   localparam logic [PW-1:0] PH_SAMPLE  = PW'(CLKS_PER_PIX / 2);
   localparam logic [9:0]    PIX_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    PIX_END    = 10'(H_TOTAL);
   localparam logic [9:0]    PIX_SAT    = 10'(H_TOTAL + 1);
   localparam logic [9:0]    H_START    = 10'(H_SYNC + H_BACK);
   localparam logic [9:0]    H_STOP     = 10'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [9:0]    V_START    = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]    V_STOP     = 10'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [9:0]    VLINE_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]    VLINE_SAT  = 10'd1023;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SEEK     = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   logic        hs_i;
   logic        vs_i;
   logic [11:0] colour_i;

`ifdef INPUT_SYNC_EN
   logic [1:0]  hs_sync;
   logic [1:0]  vs_sync;
   logic [11:0] colour_s1;
   logic [11:0] colour_s2;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hs_sync   <= 2'b11;
         vs_sync   <= 2'b11;
         colour_s1 <= '0;
         colour_s2 <= '0;
      end else begin
         hs_sync   <= {hs_sync[0], HS};
         vs_sync   <= {vs_sync[0], VS};
         colour_s1 <= COLOUR_IN;
         colour_s2 <= colour_s1;
      end
   end

   assign hs_i     = hs_sync[1];
   assign vs_i     = vs_sync[1];
   assign colour_i = colour_s2;
`else
   assign hs_i     = HS;
   assign vs_i     = VS;
   assign colour_i = COLOUR_IN;
`endif

   state_t        state;
   state_t        state_nx;
   logic          hs_q;
   logic          vs_q;
   logic [9:0]    pix;
   logic [PW-1:0] phase;
   logic [9:0]    vline;
   logic          line_seen;

   logic hs_fall;
   logic vs_fall;
   logic phase_wrap;
   logic timeout;
   logic line_bad;
   logic frame_good;
   logic visible;
   logic sample;
   logic unlock;
   logic frame_pulse;
   logic err_pulse;

   assign hs_fall    = hs_q & ~hs_i;
   assign vs_fall    = vs_q & ~vs_i;
   assign phase_wrap = (phase == PH_LAST);
   // pix only ever steps onto PIX_SAT once per missing HS, so the timeout fires once
   assign timeout    = ~hs_fall & phase_wrap & (pix == PIX_END);
   assign line_bad   = timeout |
                       (hs_fall & line_seen & ~((pix == PIX_LAST) & (phase == PH_LAST)));
   assign frame_good = (vline == VLINE_LAST);
   assign visible    = (pix >= H_START) && (pix < H_STOP) &&
                       (vline >= V_START) && (vline < V_STOP);
   assign sample     = (state == ST_LOCKED) && (phase == PH_SAMPLE) && visible &&
                       !hs_fall && !vs_fall;
   assign unlock     = (state != ST_UNLOCKED) && (state_nx == ST_UNLOCKED);
   assign LOCKED     = (state == ST_LOCKED);

   always_comb begin
      state_nx    = state;
      frame_pulse = 1'b0;
      err_pulse   = 1'b0;
      case (state)
         ST_UNLOCKED: begin
            if (vs_fall) state_nx = ST_SEEK;
         end
         ST_SEEK: begin
            if (line_bad) begin
               state_nx = ST_UNLOCKED;
            end else if (vs_fall && frame_good) begin
               state_nx    = ST_LOCKED;
               frame_pulse = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (line_bad || (vs_fall && !frame_good)) begin
               state_nx  = ST_UNLOCKED;
               err_pulse = 1'b1;
            end else if (vs_fall) begin
               frame_pulse = 1'b1;
            end
         end
         default: state_nx = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_UNLOCKED;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         pix         <= '0;
         phase       <= '0;
         vline       <= '0;
         line_seen   <= 1'b0;
         FRAME_START <= 1'b0;
         TIMING_ERR  <= 1'b0;
         PIX_VALID   <= 1'b0;
         X           <= '0;
         Y           <= '0;
         COLOUR_OUT  <= '0;
      end else begin
         state <= state_nx;
         hs_q  <= hs_i;
         vs_q  <= vs_i;

         if (hs_fall) begin
            pix   <= '0;
            phase <= '0;
         end else begin
            phase <= phase_wrap ? '0 : phase + PW'(1);
            if (phase_wrap && (pix != PIX_SAT)) pix <= pix + 10'd1;
         end

         // a VS fall lands on the line's HS fall; that line becomes line 0
         if (vs_fall) begin
            vline <= '0;
         end else if (hs_fall && (vline != VLINE_SAT)) begin
            vline <= vline + 10'd1;
         end

         if (unlock) begin
            line_seen <= 1'b0;
         end else if (hs_fall) begin
            line_seen <= 1'b1;
         end

         FRAME_START <= frame_pulse;
         TIMING_ERR  <= err_pulse;
         PIX_VALID   <= sample;
         if (sample) begin
            X          <= pix - H_START;
            Y          <= 9'(vline - V_START);
            COLOUR_OUT <= colour_i;
         end
      end
   end
endmodule
